// File: rtl/up_loader_pkg.sv
// Shared types and constants for the UART program loader.
// State encoding and default protocol bytes.
package up_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        ECHO = 3'd3,
        CSUM = 3'd4,
        RUN  = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'h55;
    localparam logic [7:0] HALT_DEFAULT = 8'hAA;

endpackage

// File: rtl/up_loader_if.sv
// UART, CPU and shared-memory signals of the loader.
// master drives the environment side, slave is the loader.
interface up_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] cpu_addr;
    logic       cpu_we;
    logic [7:0] cpu_wdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_halt;
    logic       err;

    modport master (
        output rx_data, rx_valid, tx_busy,
        output cpu_addr, cpu_we, cpu_wdata,
        input  tx_data, tx_start,
        input  mem_addr, mem_wdata, mem_we,
        input  cpu_halt, err
    );

    modport slave (
        input  rx_data, rx_valid, tx_busy,
        input  cpu_addr, cpu_we, cpu_wdata,
        output tx_data, tx_start,
        output mem_addr, mem_wdata, mem_we,
        output cpu_halt, err
    );

endinterface

// File: rtl/up_loader.sv
// Loads a program over UART into shared memory, echoing each byte
// and a checksum, then hands the memory port to the CPU.
module up_loader
    import up_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter logic [7:0] HALT_BYTE = HALT_DEFAULT
) (
    input logic      clk,
    input logic      nRst,
    up_loader_if.slave bus
);

    state_t     state;
    logic [7:0] len;
    logic [7:0] cnt;
    logic [7:0] csum;
    logic [7:0] byte_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       we_q;
    logic [7:0] tx_data_q;
    logic       tx_start_q;
    logic       err_q;
    logic       run;

    // CPU owns the memory port only in RUN; otherwise the loader drives it.
    assign run           = (state == RUN);
    assign bus.cpu_halt  = !run;
    assign bus.mem_addr  = run ? bus.cpu_addr  : addr_q;
    assign bus.mem_wdata = run ? bus.cpu_wdata : wdata_q;
    assign bus.mem_we    = run ? bus.cpu_we    : we_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.err       = err_q;

    // Load sequencer with registered write/transmit strobes.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            len        <= 8'h00;
            cnt        <= 8'h00;
            csum       <= 8'h00;
            byte_q     <= 8'h00;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            tx_start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        err_q <= 1'b0;
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (bus.rx_valid) begin
                        len   <= bus.rx_data;
                        cnt   <= 8'h00;
                        csum  <= 8'h00;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bus.rx_valid) begin
                        addr_q  <= cnt;
                        wdata_q <= bus.rx_data;
                        we_q    <= 1'b1;
                        byte_q  <= bus.rx_data;
                        csum    <= csum + bus.rx_data;
                        state   <= ECHO;
                    end
                end
                ECHO: begin
                    if (bus.rx_valid) err_q <= 1'b1;
                    if (!bus.tx_busy) begin
                        tx_data_q  <= byte_q;
                        tx_start_q <= 1'b1;
                        cnt        <= cnt + 8'd1;
                        // len==0 means 256: last byte is then at 8'hFF
                        state <= (cnt == len - 8'd1) ? CSUM : DATA;
                    end
                end
                CSUM: begin
                    if (bus.rx_valid) err_q <= 1'b1;
                    if (!bus.tx_busy) begin
                        tx_data_q  <= csum;
                        tx_start_q <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (bus.rx_valid && bus.rx_data == HALT_BYTE)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_up_loader.sv
// Self-checking bench for up_loader: scoreboard of memory writes
// and transmitted bytes, plus a vector table for CPU pass-through.
module tb_up_loader;

    logic clk  = 1'b0;
    logic nRst = 1'b0;

    up_loader_if bus ();

    up_loader dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int tx_seen = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_tx[$];

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] exp_addr;
        logic       exp_we;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] addr, input logic [7:0] b);
        exp_wr.push_back({addr, b});
        exp_tx.push_back(b);
        send(b);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 16'(exp_tx.size() + exp_wr.size()), 16'd0);
    endtask

    // Scoreboard: loader writes and every transmit are popped in order.
    always @(negedge clk) begin : mon
        logic [15:0] e;
        logic [7:0]  t;
        if (bus.mem_we && bus.cpu_halt) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got=%h@%h want=none",
                         bus.mem_wdata, bus.mem_addr);
            end else begin
                e = exp_wr.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL wr got=%h@%h want=%h@%h",
                             bus.mem_wdata, bus.mem_addr, e[7:0], e[15:8]);
                end
            end
        end
        if (bus.tx_start) begin
            tx_seen++;
            checks++;
            if (bus.tx_busy) begin
                errors++;
                $display("FAIL tx_while_busy got=1 want=0");
            end
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got=%h want=none", bus.tx_data);
            end else begin
                t = exp_tx.pop_front();
                if (bus.tx_data !== t) begin
                    errors++;
                    $display("FAIL tx got=%h want=%h", bus.tx_data, t);
                end
            end
        end
    end

    initial begin
        int base;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.tx_busy   = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = 8'h00;

        vecs[0] = '{8'h10, 1'b1, 8'h5A, 8'h10, 1'b1, 8'h5A};
        vecs[1] = '{8'h11, 1'b0, 8'h33, 8'h11, 1'b0, 8'h33};
        vecs[2] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1, 8'h00};
        vecs[3] = '{8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF};

        // reset state
        #1;
        chk("rst_halt",  bus.cpu_halt, 1);
        chk("rst_we",    bus.mem_we, 0);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_txs",   bus.tx_start, 0);
        chk("rst_txd",   bus.tx_data, 0);
        chk("rst_err",   bus.err, 0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;

        // basic three-byte load
        send(8'h55);
        send(8'h03);
        load_byte(8'h00, 8'h11);
        load_byte(8'h01, 8'h22);
        load_byte(8'h02, 8'h33);
        exp_tx.push_back(8'h66);
        wait_drain("t1_drain");
        @(negedge clk);
        chk("t1_run_halt", bus.cpu_halt, 0);

        // CPU pass-through in RUN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            bus.cpu_addr  = vecs[i].addr;
            bus.cpu_we    = vecs[i].we;
            bus.cpu_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("run_addr%0d", i),  bus.mem_addr, vecs[i].exp_addr);
            chk($sformatf("run_we%0d", i),    bus.mem_we, vecs[i].exp_we);
            chk($sformatf("run_wdata%0d", i), bus.mem_wdata, vecs[i].exp_wdata);
        end
        @(negedge clk);
        #1 bus.cpu_we = 1'b0;

        // sync and stray bytes ignored in RUN; halt byte stops the CPU
        send(8'h55);
        send(8'h12);
        chk("run_ignore", bus.cpu_halt, 0);
        send(8'hAA);
        chk("halt_set", bus.cpu_halt, 1);
        bus.cpu_addr  = 8'h20;
        bus.cpu_wdata = 8'h99;
        bus.cpu_we    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_cpu_we%0d", i), bus.mem_we, 0);
        end
        bus.cpu_we = 1'b0;

        // overrun during ECHO, with tx_busy held 50 cycles
        send(8'h55);
        send(8'h02);
        @(negedge clk);
        #1 bus.tx_busy = 1'b1;
        load_byte(8'h00, 8'hA1);
        send(8'hEE);
        chk("err_set", bus.err, 1);
        base = tx_seen;
        repeat (48) @(negedge clk);
        chk("busy_hold", 16'(tx_seen), 16'(base));
        #1 bus.tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("one_pulse", 16'(tx_seen), 16'(base + 1));
        load_byte(8'h01, 8'hA2);
        exp_tx.push_back(8'h43);
        wait_drain("t3_drain");
        @(negedge clk);
        chk("t3_run", bus.cpu_halt, 0);
        chk("err_sticky", bus.err, 1);
        send(8'hAA);
        chk("err_idle", bus.err, 1);
        send(8'h55);
        chk("err_clear", bus.err, 0);

        // 256-byte load, count byte 0
        send(8'h00);
        for (int i = 0; i < 256; i++)
            load_byte(8'(i), 8'(i));
        exp_tx.push_back(8'h80);
        wait_drain("t4_drain");
        @(negedge clk);
        chk("t4_run", bus.cpu_halt, 0);
        send(8'hAA);

        // asynchronous reset mid-load
        send(8'h55);
        send(8'h05);
        load_byte(8'h00, 8'h01);
        load_byte(8'h01, 8'h02);
        wait_drain("t5_drain");
        @(negedge clk);
        #2 nRst = 1'b0;
        #1;
        chk("arst_halt",  bus.cpu_halt, 1);
        chk("arst_we",    bus.mem_we, 0);
        chk("arst_addr",  bus.mem_addr, 0);
        chk("arst_wdata", bus.mem_wdata, 0);
        chk("arst_txs",   bus.tx_start, 0);
        chk("arst_txd",   bus.tx_data, 0);
        chk("arst_err",   bus.err, 0);
        @(negedge clk);
        nRst = 1'b1;
        send(8'h55);
        send(8'h01);
        load_byte(8'h00, 8'h9C);
        exp_tx.push_back(8'h9C);
        wait_drain("t6_drain");
        @(negedge clk);
        chk("t6_run", bus.cpu_halt, 0);

        repeat (3) @(negedge clk);
        chk("end_wr_q", 16'(exp_wr.size()), 16'd0);
        chk("end_tx_q", 16'(exp_tx.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_loader.md
UP_LOADER -- requirements
Module: up_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h55, rx byte that starts a program load.
REQ-002 Parameter HALT_BYTE, default 8'hAA, rx byte that halts the CPU during RUN.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 nRst  input  1  asynchronous active-low reset.
REQ-005 rx_data  input  8  UART receive byte, valid while rx_valid is high.
REQ-006 rx_valid  input  1  one-cycle pulse per received byte.
REQ-007 tx_busy  input  1  UART transmitter busy.
REQ-008 tx_data  output  8  byte to transmit.
REQ-009 tx_start  output  1  one-cycle transmit request.
REQ-010 cpu_addr  input  8  CPU memory address.
REQ-011 cpu_we  input  1  CPU write enable.
REQ-012 cpu_wdata  input  8  CPU write data.
REQ-013 mem_addr  output  8  shared memory address.
REQ-014 mem_wdata  output  8  shared memory write data.
REQ-015 mem_we  output  1  shared memory write enable.
REQ-016 cpu_halt  output  1  high whenever the CPU does not own the memory port.
REQ-017 err  output  1  sticky overrun flag; cleared on entry to LEN.

Function
REQ-018 States SHALL be IDLE, LEN, DATA, ECHO, CSUM and RUN; reset state is IDLE.
REQ-019 IDLE: rx_valid with rx_data==SYNC_BYTE -> LEN; other bytes ignored.
REQ-020 LEN: the next rx byte SHALL be latched as count N, with 0 meaning 256 bytes; address counter and checksum cleared; -> DATA.
REQ-021 DATA: on rx_valid, mem_addr=counter, mem_wdata=rx_data and mem_we=1 SHALL be registered, giving a one-cycle pulse the cycle after rx_valid; the byte is latched for echo; checksum += byte, mod 256; -> ECHO.
REQ-022 ECHO: first cycle with tx_busy==0 -> tx_data=latched byte and tx_start pulse for 1 cycle; the counter increments, wrapping 8'hFF->8'h00; if N bytes are written -> CSUM, else -> DATA.
REQ-023 CSUM: first cycle with tx_busy==0 -> tx_data=checksum and tx_start pulse; -> RUN.
REQ-024 rx_valid in ECHO or CSUM SHALL drop the byte and set err; the state is unaffected.
REQ-025 RUN: cpu_halt=0; mem_addr/mem_wdata/mem_we SHALL follow cpu_addr/cpu_wdata/cpu_we combinationally.
REQ-026 RUN: rx_valid with rx_data==HALT_BYTE -> IDLE; cpu_halt=1 from the next cycle; other bytes are ignored.
REQ-027 RUN: a SYNC_BYTE SHALL be ignored, because a reload requires HALT_BYTE first.
REQ-028 Outside RUN, cpu_we SHALL never reach mem_we.
REQ-029 tx_start SHALL never be asserted while tx_busy is high.

Reset
REQ-030 When nRst is low: state=IDLE, cpu_halt=1, mem_we=0, mem_addr=0, mem_wdata=0, tx_start=0, tx_data=0, err=0, counter/N/checksum=0.
REQ-031 Reset asserted mid-load SHALL abort immediately; no further memory write or tx occurs, and memory contents are left as written.

Structure
REQ-032 A shared package SHALL hold the state encoding (3-bit) and the default SYNC_BYTE/HALT_BYTE constants.
REQ-033 A single flat module suffices; no sub-module is required.

Verification
REQ-034 Reset, then rx 55,03,11,22,33 with tx_busy=0 -> writes 11@00,22@01,33@02; echoes 11,22,33; then 66 transmitted; cpu_halt falls.
REQ-035 Load with N=0 and 256 bytes of value i -> all addresses 00..FF written; counter wraps to 00; checksum 80 transmitted.
REQ-036 Hold tx_busy=1 for 50 cycles during ECHO -> tx_start stays low, then exactly one pulse after tx_busy falls.
REQ-037 rx_valid during ECHO -> err=1; byte not written; load completes normally; err clears on the next load entering LEN.
REQ-038 In RUN, CPU writes 5A@10 -> mem_we mirrors; rx AA -> cpu_halt=1; subsequent cpu_we ignored; rx 55 then re-enters LEN.
REQ-039 nRst pulsed low after two data bytes -> all outputs at reset values asynchronously; the next 55 starts a fresh load.
